// File: rtl/note_detector_pkg.sv
// Shared note codes, FSM state encodings and period thresholds for the note detector.
package note_detector_pkg;

    typedef logic [3:0] note_t;

    localparam note_t NOTE_NONE = 4'd0;
    localparam note_t NOTE_C4   = 4'd1;
    localparam note_t NOTE_D    = 4'd2;
    localparam note_t NOTE_E    = 4'd3;
    localparam note_t NOTE_F    = 4'd4;
    localparam note_t NOTE_G    = 4'd5;
    localparam note_t NOTE_A    = 4'd6;
    localparam note_t NOTE_B    = 4'd7;
    localparam note_t NOTE_C5   = 4'd8;

    // Period bounds in 100 MHz cycles; every *_HI is exclusive except C4_MAX.
    localparam logic [19:0] THR_C5_LO  = 20'd185380;
    localparam logic [19:0] THR_C5_HI  = 20'd196796;
    localparam logic [19:0] THR_B_HI   = 20'd214876;
    localparam logic [19:0] THR_A_HI   = 20'd241188;
    localparam logic [19:0] THR_G_HI   = 20'd270723;
    localparam logic [19:0] THR_F_HI   = 20'd294857;
    localparam logic [19:0] THR_E_HI   = 20'd321950;
    localparam logic [19:0] THR_D_HI   = 20'd361378;
    localparam logic [19:0] THR_C4_MAX = 20'd393693;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Led[7] is C4 and Led[0] is C5, so the lit bit walks down as the code rises.
    function automatic logic [7:0] noteToLed(input note_t code);
        logic [7:0] led;
        led = 8'h00;
        if (code >= NOTE_C4 && code <= NOTE_C5) begin
            led = 8'h80 >> (code - NOTE_C4);
        end
        return led;
    endfunction

endpackage

// File: rtl/note_detector_classifier.sv
// Combinational map from a measured period to a note code (NOTE_NONE when out of range).
module period_classifier
    import note_detector_pkg::*;
#(
    parameter int unsigned SHIFT = 0
) (
    input  logic [19:0] period_i,
    output note_t       class_o
);

    // SHIFT scales every bound down together for designs clocked slower than 100 MHz.
    localparam logic [19:0] C5_LO  = THR_C5_LO  >> SHIFT;
    localparam logic [19:0] C5_HI  = THR_C5_HI  >> SHIFT;
    localparam logic [19:0] B_HI   = THR_B_HI   >> SHIFT;
    localparam logic [19:0] A_HI   = THR_A_HI   >> SHIFT;
    localparam logic [19:0] G_HI   = THR_G_HI   >> SHIFT;
    localparam logic [19:0] F_HI   = THR_F_HI   >> SHIFT;
    localparam logic [19:0] E_HI   = THR_E_HI   >> SHIFT;
    localparam logic [19:0] D_HI   = THR_D_HI   >> SHIFT;
    localparam logic [19:0] C4_MAX = THR_C4_MAX >> SHIFT;

    always_comb begin
        class_o = NOTE_NONE;
        if (period_i < C5_LO) begin
            class_o = NOTE_NONE;
        end else if (period_i < C5_HI) begin
            class_o = NOTE_C5;
        end else if (period_i < B_HI) begin
            class_o = NOTE_B;
        end else if (period_i < A_HI) begin
            class_o = NOTE_A;
        end else if (period_i < G_HI) begin
            class_o = NOTE_G;
        end else if (period_i < F_HI) begin
            class_o = NOTE_F;
        end else if (period_i < E_HI) begin
            class_o = NOTE_E;
        end else if (period_i < D_HI) begin
            class_o = NOTE_D;
        end else if (period_i <= C4_MAX) begin
            class_o = NOTE_C4;
        end
    end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an asynchronous square wave and reports the locked musical note.
module note_detector
    import note_detector_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 524288,
    parameter int unsigned MATCH_COUNT    = 2,
    parameter int unsigned CLASS_SHIFT    = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FREQ_IN,
    output logic [3:0]  note,
    output logic        valid,
    output logic [7:0]  Led,
    output logic [19:0] period
);

    localparam logic [19:0] TIMEOUT_VAL = 20'(TIMEOUT_CYCLES);
    localparam logic [7:0]  MATCH_VAL   = 8'(MATCH_COUNT);

    logic        sync1_q, sync2_q, syncPrev_q;
    logic [1:0]  state_q, state_d;
    logic [19:0] count_q, count_d;
    logic [7:0]  matchCnt_q, matchCnt_d;
    note_t       lastClass_q, lastClass_d;
    note_t       note_q, note_d;
    logic        valid_q, valid_d;
    logic [7:0]  led_q, led_d;
    logic [19:0] period_q, period_d;
    logic        riseEdge;
    note_t       periodClass;

    period_classifier #(.SHIFT(CLASS_SHIFT)) u_classifier (
        .period_i (count_q),
        .class_o  (periodClass)
    );

    assign riseEdge = sync2_q & ~syncPrev_q;

    // An edge always wins over a timeout landing in the same cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        matchCnt_d  = matchCnt_q;
        lastClass_d = lastClass_q;
        note_d      = note_q;
        valid_d     = valid_q;
        led_d       = led_q;
        period_d    = period_q;
        if (riseEdge) begin
            count_d = 20'd1;
            if (state_q == ST_IDLE) begin
                state_d     = ST_ARM;
                matchCnt_d  = 8'd0;
                lastClass_d = NOTE_NONE;
            end else begin
                period_d    = count_q;
                lastClass_d = periodClass;
                if (periodClass == NOTE_NONE) begin
                    // A junk period drops the lock at once rather than holding a stale note.
                    state_d    = ST_ARM;
                    matchCnt_d = 8'd0;
                    note_d     = NOTE_NONE;
                    valid_d    = 1'b0;
                    led_d      = 8'h00;
                end else if (!(state_q == ST_LOCKED && periodClass == lastClass_q)) begin
                    matchCnt_d = (periodClass == lastClass_q) ? matchCnt_q + 8'd1 : 8'd1;
                    if (matchCnt_d >= MATCH_VAL) begin
                        state_d = ST_LOCKED;
                        note_d  = periodClass;
                        valid_d = 1'b1;
                        led_d   = noteToLed(periodClass);
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
        end else if (state_q != ST_IDLE) begin
            if (count_q >= TIMEOUT_VAL) begin
                state_d     = ST_IDLE;
                count_d     = 20'd0;
                matchCnt_d  = 8'd0;
                lastClass_d = NOTE_NONE;
                note_d      = NOTE_NONE;
                valid_d     = 1'b0;
                led_d       = 8'h00;
            end else begin
                count_d = count_q + 20'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            syncPrev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            count_q     <= 20'd0;
            matchCnt_q  <= 8'd0;
            lastClass_q <= NOTE_NONE;
            note_q      <= NOTE_NONE;
            valid_q     <= 1'b0;
            led_q       <= 8'h00;
            period_q    <= 20'd0;
        end else begin
            sync1_q     <= FREQ_IN;
            sync2_q     <= sync1_q;
            syncPrev_q  <= sync2_q;
            state_q     <= state_d;
            count_q     <= count_d;
            matchCnt_q  <= matchCnt_d;
            lastClass_q <= lastClass_d;
            note_q      <= note_d;
            valid_q     <= valid_d;
            led_q       <= led_d;
            period_q    <= period_d;
        end
    end

    assign note   = note_q;
    assign valid  = valid_q;
    assign Led    = led_q;
    assign period = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench: a tone-level reference model checked every cycle, plus pinned literals.
module tb_note_detector;

    localparam int TIMEOUT = 4096;
    localparam int MATCH   = 2;
    localparam int SH      = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FREQ_IN = 1'b0;
    logic [3:0]  note;
    logic        valid;
    logic [7:0]  Led;
    logic [19:0] period;

    logic [19:0] clsPeriod = 20'd0;
    logic [3:0]  clsClass;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    note_detector #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .MATCH_COUNT    (MATCH),
        .CLASS_SHIFT    (SH)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .FREQ_IN (FREQ_IN),
        .note    (note),
        .valid   (valid),
        .Led     (Led),
        .period  (period)
    );

    period_classifier #(.SHIFT(0)) refCls (
        .period_i (clsPeriod),
        .class_o  (clsClass)
    );

    always #5 CLK = ~CLK;

    // Note table from highest pitch (shortest period) down: upper bound and code.
    function automatic int classifyRef(input int p, input int sh);
        int ub[8]    = '{196796, 214876, 241188, 270723, 294857, 321950, 361378, 393694};
        int codes[8] = '{8, 7, 6, 5, 4, 3, 2, 1};
        if (p < (185380 >> sh)) return 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                if (p <= (393693 >> sh)) return codes[i];
            end else if (p < (ub[i] >> sh)) begin
                return codes[i];
            end
        end
        return 0;
    endfunction

    function automatic logic [7:0] ledFor(input int n);
        logic [7:0] v;
        v = 8'h00;
        if (n >= 1 && n <= 8) v[8 - n] = 1'b1;
        return v;
    endfunction

    // Reference model: FREQ_IN seen through a 3-sample delay, then tone-level bookkeeping.
    int cyc = 0, lastEdge = 0, trailClass = 0, trailLen = 0;
    int expNote = 0, expPeriod = 0;
    bit expValid = 1'b0, armed = 1'b0;
    bit x1 = 1'b0, x2 = 1'b0, x3 = 1'b0;

    always @(posedge CLK) begin
        int p, c;
        cyc++;
        if (RESET) begin
            x1 = 0; x2 = 0; x3 = 0;
            armed = 0; trailClass = 0; trailLen = 0;
            expNote = 0; expValid = 0; expPeriod = 0;
        end else begin
            if (x2 && !x3) begin
                if (!armed) begin
                    armed = 1; trailClass = 0; trailLen = 0;
                end else begin
                    p = cyc - lastEdge;
                    expPeriod = p;
                    c = classifyRef(p, SH);
                    if (c == 0) begin
                        trailClass = 0; trailLen = 0; expNote = 0; expValid = 0;
                    end else begin
                        if (c == trailClass) trailLen++;
                        else begin trailClass = c; trailLen = 1; end
                        if (trailLen >= MATCH) begin expNote = c; expValid = 1; end
                    end
                end
                lastEdge = cyc;
            end else if (armed && (cyc - lastEdge) == TIMEOUT) begin
                armed = 0; trailClass = 0; trailLen = 0; expNote = 0; expValid = 0;
            end
            x3 = x2; x2 = x1; x1 = FREQ_IN;
        end
    end

    always @(negedge CLK) begin
        logic [7:0] expLed;
        if (checking) begin
            expLed = expValid ? ledFor(expNote) : 8'h00;
            checks++;
            if (note !== 4'(expNote) || valid !== expValid || Led !== expLed || period !== 20'(expPeriod)) begin
                errors++;
                $display("[TB] FAIL cycle%0d outputs: got note=%0d valid=%0b Led=%h period=%0d, need note=%0d valid=%0b Led=%h period=%0d",
                         cyc, note, valid, Led, period, expNote, expValid, expLed, expPeriod);
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, need %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input int per, input int n);
        for (int k = 0; k < n; k++) begin
            FREQ_IN = 1'b1;
            repeat (per / 2) @(negedge CLK);
            FREQ_IN = 1'b0;
            repeat (per - per / 2) @(negedge CLK);
        end
    endtask

    task automatic pulseReset();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        int p, n;
        repeat (3) @(negedge CLK);
        checking = 1'b1;
        checkOutput("reset note", note, 0);
        checkOutput("reset Led", Led, 0);
        checkOutput("reset period", period, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // C4 (382226 >> 8 = 1493) locks on the third rising edge.
        applyStimulus(1493, 3);
        checkOutput("C4 note", note, 1);
        checkOutput("C4 valid", valid, 1);
        checkOutput("C4 Led", Led, 8'h80);
        checkOutput("C4 period", period, 1493);

        // A (887) then E (1185): A holds through the first E period.
        applyStimulus(887, 3);
        checkOutput("A note", note, 6);
        applyStimulus(1185, 2);
        checkOutput("A held during E", note, 6);
        applyStimulus(1185, 1);
        checkOutput("E note", note, 3);
        checkOutput("E Led", Led, 8'h20);

        // Tone stops high: timeout clears outputs but keeps the last period.
        FREQ_IN = 1'b1;
        repeat (TIMEOUT + 20) @(negedge CLK);
        checkOutput("timeout valid", valid, 0);
        checkOutput("timeout Led", Led, 0);
        checkOutput("timeout period", period, 1185);
        FREQ_IN = 1'b0;
        repeat (50) @(negedge CLK);

        // G (1000) with a 300-cycle glitch period.
        applyStimulus(1000, 3);
        checkOutput("G note", note, 5);
        applyStimulus(300, 1);
        applyStimulus(1000, 1);
        checkOutput("glitch note", note, 0);
        checkOutput("glitch valid", valid, 0);
        applyStimulus(1000, 2);
        checkOutput("G relock", note, 5);

        // D (1330), reset pulse mid-period, relock needs three fresh edges.
        applyStimulus(1330, 3);
        checkOutput("D note", note, 2);
        FREQ_IN = 1'b1;
        repeat (400) @(negedge CLK);
        pulseReset();
        checkOutput("mid reset note", note, 0);
        checkOutput("mid reset period", period, 0);
        FREQ_IN = 1'b0;
        repeat (300) @(negedge CLK);
        applyStimulus(1330, 2);
        checkOutput("D after 2 edges", valid, 0);
        applyStimulus(1330, 1);
        checkOutput("D relock", note, 2);

        // Classifier bounds at full scale.
        clsPeriod = 20'd196796; #1 checkOutput("cls 196796", clsClass, 7);
        clsPeriod = 20'd185379; #1 checkOutput("cls 185379", clsClass, 0);
        clsPeriod = 20'd185380; #1 checkOutput("cls 185380", clsClass, 8);
        clsPeriod = 20'd393693; #1 checkOutput("cls 393693", clsClass, 1);
        clsPeriod = 20'd393694; #1 checkOutput("cls 393694", clsClass, 0);
        for (int i = 0; i < 200; i++) begin
            p = int'($urandom_range(150000, 420000));
            clsPeriod = 20'(p);
            #1 checkOutput("cls random", clsClass, classifyRef(p, 0));
        end
        @(negedge CLK);

        // Random tones, glitches and resets, checked cycle by cycle.
        for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 9))
                0: applyStimulus(int'($urandom_range(200, 700)), 1);
                1: pulseReset();
                default: begin
                    p = int'($urandom_range(700, 1600));
                    n = int'($urandom_range(1, 3));
                    applyStimulus(p, n);
                end
            endcase
        end
        repeat (10) @(negedge CLK);

        checking = 1'b0;
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
